// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv -- iterative RV32M multiply/divide execute unit
//
// Sits beside the single-cycle ALU in EX. One operation is accepted per start
// pulse while idle; the unit then iterates one radix-2 step per clock on a
// 2*XLEN accumulator (shift-add for multiplies, restoring shift-subtract for
// divides) and returns the sign-corrected result on a one-cycle done pulse.
// Divide-by-zero and signed overflow are resolved without iterating.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   start_i   in   operation request, sampled only in IDLE
//   op_i      in   funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   reg1_i    in   rs1 value (multiplicand / dividend)
//   reg2_i    in   rs2 value (multiplier / divisor)
//   wd_i      in   destination register
//   wreg_i    in   write-enable tag
//   flush_i   in   branch flush, cancels any operation in progress
//   busy_o    out  stall request to the pipeline controller
//   done_o    out  one-cycle result-valid pulse
//   wdata_o   out  result (holds until the next completion)
//   wd_o      out  destination register captured at start
//   wreg_o    out  captured write enable, qualified by done_o
// ---------------------------------------------------------------------------
module ex_muldiv #(
   parameter int XLEN      = 32,
   parameter int REGADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [2:0]           op_i,
   input  logic [XLEN-1:0]      reg1_i,
   input  logic [XLEN-1:0]      reg2_i,
   input  logic [REGADDR_W-1:0] wd_i,
   input  logic                 wreg_i,
   input  logic                 flush_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [XLEN-1:0]      wdata_o,
   output logic [REGADDR_W-1:0] wd_o,
   output logic                 wreg_o
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ONES_VAL = {XLEN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic [CNT_W-1:0]      cnt_reg;
   logic [2*XLEN-1:0]     acc_reg;
   logic [XLEN-1:0]       b_reg;
   logic [2:0]            op_reg;
   logic                  neg_reg;
   logic [REGADDR_W-1:0]  wd_reg;
   logic                  wreg_reg;
   logic [XLEN-1:0]       wdata_reg;

   // ------------------------------------------------------------------------
   // Accept-time decode: operand magnitudes, result sign and fast-path result
   // ------------------------------------------------------------------------
   logic                  accept;
   logic                  a_signed, b_signed;
   logic                  a_neg, b_neg;
   logic [XLEN-1:0]       a_abs, b_abs;
   logic                  neg_in;
   logic                  div_zero, div_ovf, fast;
   logic [XLEN-1:0]       fast_result;

   assign accept = (state_reg == S_IDLE) && start_i && !flush_i;

   always_comb begin
      a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                 (op_i == OP_DIV)  || (op_i == OP_REM);
      b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
      a_neg    = a_signed && reg1_i[XLEN-1];
      b_neg    = b_signed && reg2_i[XLEN-1];
      a_abs    = a_neg ? -reg1_i : reg1_i;
      b_abs    = b_neg ? -reg2_i : reg2_i;

      // Remainders follow the dividend; products and quotients are negative
      // when exactly one signed operand is negative.
      if (op_i[2] && op_i[1])
         neg_in = a_neg;
      else
         neg_in = a_neg ^ b_neg;

      div_zero = op_i[2] && (reg2_i == '0);
      // Only the signed forms (DIV, REM) have op_i[0] clear.
      div_ovf  = op_i[2] && !op_i[0] && (reg1_i == MIN_VAL) && (reg2_i == ONES_VAL);
      fast     = div_zero || div_ovf;

      fast_result = '0;
      if (div_zero)
         fast_result = op_i[1] ? reg1_i : ONES_VAL;
      else if (div_ovf)
         fast_result = op_i[1] ? '0 : reg1_i;
   end

   // ------------------------------------------------------------------------
   // One radix-2 iteration step and final sign correction / selection
   // ------------------------------------------------------------------------
   logic [XLEN:0]         mul_sum;
   logic [XLEN:0]         rem_sh;
   logic [XLEN:0]         diff;
   logic [2*XLEN-1:0]     acc_next;
   logic [2*XLEN-1:0]     prod_fix;
   logic [XLEN-1:0]       div_word, div_fix;
   logic [XLEN-1:0]       result;
   logic                  last_step;

   assign last_step = (cnt_reg == CNT_W'(XLEN - 1));

   always_comb begin
      // Multiply: add the multiplicand into the high half when the current
      // multiplier bit (acc LSB) is set, then shift the whole accumulator
      // right; the carry lands in the top bit.
      mul_sum = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                (acc_reg[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});

      // Divide: shift the partial remainder left pulling in the next dividend
      // bit; subtract the divisor and keep the difference only if it did not
      // go negative. Quotient bits shift into the low half.
      rem_sh = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
      diff   = rem_sh - {1'b0, b_reg};

      if (op_reg[2]) begin
         if (diff[XLEN])
            acc_next = {rem_sh[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
         else
            acc_next = {diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc_reg[XLEN-1:1]};
      end

      // The full double-width product is negated so the high half receives
      // the borrow from the low half.
      prod_fix = neg_reg ? -acc_next : acc_next;
      div_word = op_reg[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
      div_fix  = neg_reg ? -div_word : div_word;

      if (op_reg[2])
         result = div_fix;
      else if (op_reg == OP_MUL)
         result = prod_fix[XLEN-1:0];
      else
         result = prod_fix[2*XLEN-1:XLEN];
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic (flush returns to IDLE from anywhere)
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept)
               state_next = fast ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (last_step)
               state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (flush_i)
         state_next = S_IDLE;
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      busy_o  = (state_reg == S_RUN) || accept;
      done_o  = (state_reg == S_DONE) && !flush_i;
      wreg_o  = done_o && wreg_reg;
      wdata_o = wdata_reg;
      wd_o    = wd_reg;
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg   <= '0;
         acc_reg   <= '0;
         b_reg     <= '0;
         op_reg    <= '0;
         neg_reg   <= 1'b0;
         wd_reg    <= '0;
         wreg_reg  <= 1'b0;
         wdata_reg <= '0;
      end else if (accept) begin
         cnt_reg   <= '0;
         acc_reg   <= {{XLEN{1'b0}}, a_abs};
         b_reg     <= b_abs;
         op_reg    <= op_i;
         neg_reg   <= neg_in;
         wd_reg    <= wd_i;
         wreg_reg  <= wreg_i;
         if (fast)
            wdata_reg <= fast_result;
      end else if ((state_reg == S_RUN) && !flush_i) begin
         acc_reg <= acc_next;
         cnt_reg <= cnt_reg + CNT_W'(1);
         if (last_step)
            wdata_reg <= result;
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic [2:0]  op_i = '0;
   logic [31:0] reg1_i = '0;
   logic [31:0] reg2_i = '0;
   logic [4:0]  wd_i = '0;
   logic        wreg_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        busy_o, done_o, wreg_o;
   logic [31:0] wdata_o;
   logic [4:0]  wd_o;

   int checks = 0;
   int failures = 0;

   ex_muldiv #(.XLEN(32), .REGADDR_W(5)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
      .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: RV32M semantics in plain 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ub = longint'({32'b0, b});
      logic [63:0] p;
      int ia = $signed(a);
      int ib = $signed(b);
      case (op)
         3'd0: begin p = a * b;             return p[31:0];  end
         3'd1: begin p = sa * sb;           return p[63:32]; end
         3'd2: begin p = sa * ub;           return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_latency(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
      if (op[2] && (b == 0)) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 33;
   endfunction

   // Present an operation for one cycle and let the accept edge pass.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wreg);
      @(negedge clk);
      op_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg; start_i = 1'b1;
      #1 check("busy_on_issue", {31'b0, busy_o}, 32'd1);
      @(posedge clk);
      #1 start_i = 1'b0;
      reg1_i = $urandom; reg2_i = $urandom; wd_i = 5'($urandom);
   endtask

   // Wait (bounded) for done_o; lat is the expected number of negedges after
   // the call until done_o is seen.
   task automatic await_done(input string tag, input int lat, input logic [31:0] data,
                             input logic [4:0] wd, input logic wreg);
      int n = 0;
      bit seen = 0;
      bit busy_ok = 1;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (done_o) seen = 1;
         else if (!busy_o) busy_ok = 0;
      end
      check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
      check({tag, "_latency"}, 32'(n), 32'(lat));
      check({tag, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
      check({tag, "_wdata"}, wdata_o, data);
      check({tag, "_wd"}, {27'b0, wd_o}, {27'b0, wd});
      check({tag, "_wreg"}, {31'b0, wreg_o}, {31'b0, wreg});
      check({tag, "_busy_at_done"}, {31'b0, busy_o}, 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'b0, done_o}, 32'd0);
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] wd, input logic wreg);
      issue(op, a, b, wd, wreg);
      await_done(tag, model_latency(op, a, b), model(op, a, b), wd, wreg);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          pulses;

      // Reset state
      #2;
      check("rst_busy",  {31'b0, busy_o}, 32'd0);
      check("rst_done",  {31'b0, done_o}, 32'd0);
      check("rst_wdata", wdata_o, 32'd0);
      check("rst_wd",    {27'b0, wd_o}, 32'd0);
      check("rst_wreg",  {31'b0, wreg_o}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Directed cases
      run("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd3,  1'b1);
      check("mul_value", wdata_o, 32'hFFFFFFEB);
      run("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  1'b1);
      check("mulhu_value", wdata_o, 32'hFFFFFFFE);
      run("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  1'b0);
      check("mulh_value", wdata_o, 32'h00000000);
      run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd6,  1'b1);
      check("mulhsu_value", wdata_o, 32'hFFFFFFFF);
      run("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd7,  1'b1);
      check("div_value", wdata_o, 32'hFFFFFFFD);
      run("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd8,  1'b1);
      check("rem_value", wdata_o, 32'hFFFFFFFF);
      run("divu_z", 3'd5, 32'd5,        32'd0,        5'd9,  1'b1);
      check("divu_z_value", wdata_o, 32'hFFFFFFFF);
      run("remu_z", 3'd7, 32'd5,        32'd0,        5'd10, 1'b1);
      check("remu_z_value", wdata_o, 32'd5);
      run("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 1'b1);
      check("div_ov_value", wdata_o, 32'h80000000);
      run("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 1'b1);
      check("rem_ov_value", wdata_o, 32'd0);

      // Flush ten cycles into a DIVU: cancelled, no done ever
      issue(3'd5, 32'd1000, 32'd7, 5'd13, 1'b1);
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      @(negedge clk);
      check("flush_busy", {31'b0, busy_o}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_o) pulses++;
      end
      check("flush_no_done", 32'(pulses), 32'd0);
      repeat (2) @(negedge clk);
      run("after_flush", 3'd5, 32'd1000, 32'd7, 5'd14, 1'b1);

      // Flush together with start in IDLE: nothing accepted
      @(negedge clk);
      op_i = 3'd5; reg1_i = 32'd9; reg2_i = 32'd0; start_i = 1'b1; flush_i = 1'b1;
      #1 check("flush_start_busy", {31'b0, busy_o}, 32'd0);
      @(posedge clk);
      #1 start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      check("flush_start_no_done", {31'b0, done_o}, 32'd0);

      // Flush during the DONE cycle masks done_o and wreg_o
      issue(3'd5, 32'd5, 32'd0, 5'd15, 1'b1);
      @(negedge clk);
      check("done_before_flush", {31'b0, done_o}, 32'd1);
      flush_i = 1'b1;
      #1 check("flush_done_done", {31'b0, done_o}, 32'd0);
      check("flush_done_wreg", {31'b0, wreg_o}, 32'd0);
      @(posedge clk);
      #1 flush_i = 1'b0;

      // Start while busy is ignored
      issue(3'd0, 32'd1234, 32'd5678, 5'd16, 1'b1);
      repeat (5) @(negedge clk);
      op_i = 3'd5; reg1_i = 32'd99; reg2_i = 32'd0; wd_i = 5'd30; start_i = 1'b1;
      #1 check("busy_run", {31'b0, busy_o}, 32'd1);
      @(posedge clk);
      #1 start_i = 1'b0;
      await_done("start_busy", 28, model(3'd0, 32'd1234, 32'd5678), 5'd16, 1'b1);

      // Reset mid-RUN
      issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd17, 1'b1);
      repeat (8) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid_busy",  {31'b0, busy_o}, 32'd0);
      check("rstmid_done",  {31'b0, done_o}, 32'd0);
      check("rstmid_wdata", wdata_o, 32'd0);
      check("rstmid_wd",    {27'b0, wd_o}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_busy", {31'b0, busy_o}, 32'd0);
      run("post_rst", 3'd7, 32'd100, 32'd7, 5'd18, 1'b1);

      // Randomized operations against the model
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: rb = -32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         run("rand", rop, ra, rb, 5'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
